// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit stage fed by the byte FIFO. It pops one
// word per frame and sends it as start bit, DATA_SIZE data bits (LSB first)
// and a stop bit, with every bit held for CLKS_PER_BIT clocks.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for enable with a non-empty FIFO
// START  | start bit (tx low)
// DATA   | data bits, LSB first, shifted out of shift_q
// PARITY | even parity of the latched byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (tx high); tx_done pulses when it completes
module uart_tx_serializer #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_SIZE) + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_SIZE-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   fifo_read_q, fifo_read_d;
  logic                   tx_done_q, tx_done_d;
  logic                   bit_end;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  // Last clock of the current bit period.
  assign bit_end = (cnt_q == LAST_CNT);

  // Next-state logic; registered outputs are derived from the next state so
  // they change on the same edge as the state register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    fifo_read_d = 1'b0;
    tx_done_d   = 1'b0;
    tx_d        = 1'b1;
    busy_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // fifo_empty is only looked at here, so the stale flag seen right
        // after a pop can never cause a second read.
        if (enable && !fifo_empty) begin
          shift_d     = fifo_data;
          idx_d       = '0;
          fifo_read_d = 1'b1;
          state_d     = START;
`ifdef UART_TX_PARITY_EN
          parity_d    = ^fifo_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d     = '0;
          tx_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      fifo_read_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      fifo_read_q <= fifo_read_d;
      tx_done_q   <= tx_done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the latched byte, captured together with the pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign fifo_read = fifo_read_q;
  assign tx_done   = tx_done_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit stage sitting directly downstream of the byte FIFO. It consumes the FIFO's read-data and empty flag, and pulses the FIFO read strobe.
- Each byte is serialized as an 8N1 frame on the tx line: start bit, DATA_SIZE data bits LSB first, stop bit.
- Bit timing comes from an internal baud counter driven by the single system clock.

Parameters:
- DATA_SIZE, 8, data bits per frame; must match the FIFO word width.
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  when high, new frames may start; when low, no new frame starts.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_SIZE  FIFO head word; combinational, valid whenever fifo_empty is low.
- fifo_read  output  1  one-cycle pulse that pops the FIFO head.
- tx  output  1  serial line; idles high.
- busy  output  1  high from frame start through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse on the cycle after the stop bit completes.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, tx=1, busy=0, fifo_read=0, tx_done=0; baud counter, bit index and shift register cleared. Asserting reset mid-frame aborts immediately, tx returns high, and the FIFO is not popped again.
- Registered outputs: tx, busy, fifo_read and tx_done are all registers.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets to 0 on every state change. Bit boundary = counter at CLKS_PER_BIT-1.
- Counter width: $clog2(CLKS_PER_BIT); bit index width: $clog2(DATA_SIZE)+1.
- IDLE:
  - tx=1.
  - If enable & ~fifo_empty: latch fifo_data into the shift register, pulse fifo_read for exactly 1 cycle, set busy=1, go to START.
  - Latency: frame start (tx falls) is 1 cycle after the start condition is sampled.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index.
  - After bit DATA_SIZE-1, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then: busy=0, tx_done=1 for one cycle, go to IDLE.
- Frame length: exactly (DATA_SIZE+2)*CLKS_PER_BIT cycles, from tx falling to the end of the stop bit.
- Back-to-back frames:
  - The FIFO empty flag is registered and updates 1 cycle after fifo_read. This block does not re-sample fifo_empty until it returns to IDLE, so a single pop never double-reads.
  - Minimum inter-frame idle gap: 1 cycle (the IDLE cycle).
- enable deasserted mid-frame: the current frame completes normally. Only the next start is inhibited.
- fifo_empty rising mid-frame: no effect; the byte is already latched.
- fifo_data changing after the pop: no effect on the frame in flight.
- fifo_read is never asserted when fifo_empty is high or when state≠IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the latched byte) for CLKS_PER_BIT cycles. Frame length becomes (DATA_SIZE+3)*CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; 8N1 frames only.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and DATA_SIZE=8.
- Reset with reset_n=0, enable=1, fifo_empty=0 -> tx=1, busy=0, fifo_read=0 throughout; release reset -> fifo_read pulses on the first active edge.
- Single byte 0xA5, enable=1 -> one fifo_read pulse. tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total). tx_done pulses once; busy is high for exactly 40 cycles.
- Two bytes 0x00 then 0xFF, fifo_empty low throughout -> exactly 2 fifo_read pulses ≥41 cycles apart. The second frame's start bit begins 1 idle cycle after the first stop bit ends.
- enable dropped during bit 3 of 0x3C -> frame completes intact. No further fifo_read while enable=0; the next frame starts 1 cycle after enable returns.
- reset_n pulsed low during DATA bit 5 -> tx=1 and busy=0 immediately (asynchronous). No extra fifo_read; the next pending byte starts a fresh full frame after release.
- With UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 after the data bits; frame is 44 cycles. With byte 0x03 -> parity bit 0.
